// File: rtl/delay_arbiter.sv
// Round-robin arbiter that grants one requester at a time a shared tick-based delay.
// One prescaler and one remaining-tick counter serve every requester.
module delay_arbiter #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int PRESCALE = 50000
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       len,
  input  logic                 abort,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         done,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner
);

  localparam int IW = $clog2(N);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [IW-1:0] ptr_q,    ptr_d;
  logic [IW-1:0] owner_q,  owner_d;
  logic [W-1:0]  remain_q, remain_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [N-1:0]  ack_q,    ack_d;

  logic [W-1:0]  len_arr [N];
  logic          found;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   cand;
  logic [IW:0]   ptr_nxt;

  for (genvar gi = 0; gi < N; gi++) begin : g_len
    assign len_arr[gi] = len[gi*W +: W];
  end

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, grant_idx} + (IW+1)'(1);
    if (ptr_nxt == (IW+1)'(N)) begin
      ptr_nxt = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    remain_d = remain_q;
    presc_d  = presc_q;
    ack_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d  = grant_idx;
          ack_d    = {{(N-1){1'b0}}, 1'b1} << grant_idx;
          remain_d = len_arr[grant_idx];
          presc_d  = '0;
          ptr_d    = ptr_nxt[IW-1:0];
          state_d  = (len_arr[grant_idx] == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over a coinciding final tick
        if (abort) begin
          state_d = ST_IDLE;
        end else if (presc_q == PW'(PRESCALE - 1)) begin
          presc_d  = '0;
          remain_d = remain_q - W'(1);
          if (remain_q == W'(1)) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      remain_q <= '0;
      presc_q  <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      remain_q <= remain_d;
      presc_q  <= presc_d;
      ack_q    <= ack_d;
    end
  end

  assign ack   = ack_q;
  assign done  = (state_q == ST_DONE) ? ({{(N-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign busy  = (state_q != ST_IDLE);
  assign owner = owner_q;

endmodule
